// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_VALID = 2'd3
    } FetchState;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_redirect_latch.sv
// Redirect qualification: word-aligned target, pending target held across an
// in-flight fetch (latest wins), and a one-cycle misalignment pulse after capture.
module fetch_redirect_latch
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_en,
    input  logic        shouldUseNewPC,
    input  logic [31:0] branchTo,
    output logic        redirect,
    output logic [31:0] target_pc,
    output logic [31:0] pending_pc,
    output logic        misalignedPC
);

    logic [31:0] pending_q;
    logic        misaligned_q;

    // A redirect only exists while the fetch FSM is willing to take one.
    assign redirect  = capture_en && shouldUseNewPC;
    assign target_pc = word_align(branchTo);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect && is_misaligned(branchTo);
            if (redirect) begin
                pending_q <= target_pc;
            end
        end
    end

    assign pending_pc   = pending_q;
    assign misalignedPC = misaligned_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch stage: one outstanding word fetch, one held instruction.
// Ack at t gives instrValid at t+1; accept at t+1 gives the next request at t+2.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        shouldUseNewPC,
    input  logic [31:0] branchTo,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    input  logic        instrReady,
    output logic [31:0] instr,
    output logic [31:0] instrPC,
    output logic [31:0] pcAddress,
    output logic        misalignedPC
);

    FetchState   state_q;
    FetchState   state_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic        capture_instr;

    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] pc_address_q;

    logic        redirect_en;
    logic        redirect;
    logic [31:0] target_pc;
    logic [31:0] pending_pc;

    // Boot cycle ignores redirects entirely.
    assign redirect_en = (state_q != S_BOOT);

    fetch_redirect_latch u_redirect (
        .clk            (clk),
        .rst            (rst),
        .capture_en     (redirect_en),
        .shouldUseNewPC (shouldUseNewPC),
        .branchTo       (branchTo),
        .redirect       (redirect),
        .target_pc      (target_pc),
        .pending_pc     (pending_pc),
        .misalignedPC   (misalignedPC)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        capture_instr = 1'b0;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imemAck && redirect) begin
                    fetch_pc_d = target_pc;
                end else if (imemAck) begin
                    capture_instr = 1'b1;
                    fetch_pc_d    = fetch_pc_q + INSTR_BYTES;
                    state_d       = S_VALID;
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The old request must complete before the new target is issued.
                if (imemAck) begin
                    fetch_pc_d = redirect ? target_pc : pending_pc;
                    state_d    = S_REQ;
                end
            end
            S_VALID: begin
                if (redirect) begin
                    fetch_pc_d = target_pc;
                    state_d    = S_REQ;
                end else if (instrReady) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q      <= '0;
            instr_pc_q   <= '0;
            pc_address_q <= '0;
        end else if (capture_instr) begin
            instr_q      <= imemRdata;
            instr_pc_q   <= fetch_pc_q;
            pc_address_q <= fetch_pc_q + INSTR_BYTES;
        end
    end

    assign imemReq    = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imemAddr   = fetch_pc_q;
    assign instrValid = (state_q == S_VALID);
    assign instr      = instr_q;
    assign instrPC    = instr_pc_q;
    assign pcAddress  = pc_address_q;

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (imemReq && !imemAck) |=> $stable(imemAddr));

    a_valid_held: assert property (@(posedge clk) disable iff (rst)
        (instrValid && !instrReady && !shouldUseNewPC) |=> (instrValid && $stable(instr)));

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RV   = 32'h0040_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        shouldUseNewPC;
    logic [31:0] branchTo;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic [31:0] pcAddress;
    logic        misalignedPC;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .rst            (rst),
        .shouldUseNewPC (shouldUseNewPC),
        .branchTo       (branchTo),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemAck        (imemAck),
        .imemRdata      (imemRdata),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .instr          (instr),
        .instrPC        (instrPC),
        .pcAddress      (pcAddress),
        .misalignedPC   (misalignedPC)
    );

    always #5 clk = ~clk;

    // One row = one cycle: expected outputs seen in that cycle, inputs driven in it.
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] target;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pca;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ack, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] target, input logic rdy,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic [31:0] e_pca,
                                input logic e_mis);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.redir = redir; v.target = target; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_pca = e_pca; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic redir,
                         input logic [31:0] target, input logic rdy);
        imemAck        = ack;
        imemRdata      = rdata;
        shouldUseNewPC = redir;
        branchTo       = target;
        instrReady     = rdy;
    endtask

    initial begin
        // ack rdata redir target rdy | req addr valid instr pc pca mis
        tbl.push_back(mk(1, 32'hA000_0000, 0, 0, 1,  1, RV,            0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              0, 0,             1, 32'hA000_0000, RV, 32'h0040_0004, 0));
        tbl.push_back(mk(1, 32'hA000_0001, 0, 0, 1,  1, 32'h0040_0004, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0,          0, 0,             1, 32'hA000_0001, 32'h0040_0004, 32'h0040_0008, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              0, 0,             1, 32'hA000_0001, 32'h0040_0004, 32'h0040_0008, 0));
        tbl.push_back(mk(1, 32'hA000_0002, 0, 0, 1,  1, 32'h0040_0008, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              0, 0,             1, 32'hA000_0002, 32'h0040_0008, 32'h0040_000C, 0));
        // delayed ack with redirect mid-wait
        tbl.push_back(mk(0, 0, 0, 0, 1,              1, 32'h0040_000C, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0040_0100, 1,  1, 32'h0040_000C, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              1, 32'h0040_000C, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, JUNK, 0, 0, 1,           1, 32'h0040_000C, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'hB000_0000, 0, 0, 1,  1, 32'h0040_0100, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              0, 0,             1, 32'hB000_0000, 32'h0040_0100, 32'h0040_0104, 0));
        tbl.push_back(mk(1, 32'hB000_0001, 0, 0, 1,  1, 32'h0040_0104, 0, 0, 0, 0, 0));
        // redirect beats a ready handshake, then same-cycle ack+redirect
        tbl.push_back(mk(0, 0, 1, 32'h0040_0200, 1,  0, 0,             1, 32'hB000_0001, 32'h0040_0104, 32'h0040_0108, 0));
        tbl.push_back(mk(1, JUNK, 1, 32'h0040_0300, 1, 1, 32'h0040_0200, 0, 0, 0, 0, 0));
        // two redirects while draining: latest wins
        tbl.push_back(mk(0, 0, 1, 32'h0040_0400, 1,  1, 32'h0040_0300, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0040_0500, 1,  1, 32'h0040_0300, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, JUNK, 0, 0, 1,           1, 32'h0040_0300, 0, 0, 0, 0, 0));
        // misaligned target
        tbl.push_back(mk(0, 0, 1, 32'h0040_0602, 1,  1, 32'h0040_0500, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, JUNK, 0, 0, 1,           1, 32'h0040_0500, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'hC000_0000, 0, 0, 1,  1, 32'h0040_0600, 0, 0, 0, 0, 0));
        // redirect with ready low, then wraparound
        tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 0,  0, 0,             1, 32'hC000_0000, 32'h0040_0600, 32'h0040_0604, 0));
        tbl.push_back(mk(1, 32'hC000_0001, 0, 0, 1,  1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              0, 0,             1, 32'hC000_0001, 32'hFFFF_FFFC, 32'h0000_0000, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0040_0700, 1,  1, 32'h0000_0000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1,              1, 32'h0000_0000, 0, 0, 0, 0, 0));

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        chk("reset imemReq", 32'(imemReq), 32'd0);
        chk("reset instrValid", 32'(instrValid), 32'd0);
        chk("reset instr", instr, 32'd0);
        chk("reset instrPC", instrPC, 32'd0);
        chk("reset pcAddress", pcAddress, 32'd0);
        chk("reset misalignedPC", 32'(misalignedPC), 32'd0);
        rst = 1'b0;
        cyc();

        foreach (tbl[i]) begin
            chk($sformatf("row%0d imemReq", i), 32'(imemReq), 32'(tbl[i].e_req));
            chk($sformatf("row%0d instrValid", i), 32'(instrValid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d misalignedPC", i), 32'(misalignedPC), 32'(tbl[i].e_mis));
            if (tbl[i].e_req)
                chk($sformatf("row%0d imemAddr", i), imemAddr, tbl[i].e_addr);
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
                chk($sformatf("row%0d instrPC", i), instrPC, tbl[i].e_pc);
                chk($sformatf("row%0d pcAddress", i), pcAddress, tbl[i].e_pca);
            end
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].redir, tbl[i].target, tbl[i].rdy);
            cyc();
        end

        // Reset while draining; acks during reset and boot must be ignored.
        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        cyc();
        chk("drain reset imemReq", 32'(imemReq), 32'd0);
        chk("drain reset instrValid", 32'(instrValid), 32'd0);
        chk("drain reset instr", instr, 32'd0);
        drive(1, JUNK, 0, 0, 1);
        cyc();
        rst = 1'b0;
        drive(1, JUNK, 1, 32'h0012_3402, 1);
        cyc();
        chk("boot first imemReq", 32'(imemReq), 32'd1);
        chk("boot first imemAddr", imemAddr, RV);
        chk("boot ack ignored", 32'(instrValid), 32'd0);
        chk("boot redirect no pulse", 32'(misalignedPC), 32'd0);

        // Drain ack coinciding with a new redirect: same-cycle target beats pending.
        drive(0, 0, 1, 32'h0040_0800, 1);
        cyc();
        chk("drain hold addr", imemAddr, RV);
        drive(1, JUNK, 1, 32'h0040_0900, 1);
        cyc();
        chk("drain same-cycle req", 32'(imemReq), 32'd1);
        chk("drain same-cycle addr", imemAddr, 32'h0040_0900);
        chk("drain data dropped", 32'(instrValid), 32'd0);
        drive(1, 32'hD000_0000, 0, 0, 1);
        cyc();
        chk("final instrValid", 32'(instrValid), 32'd1);
        chk("final instr", instr, 32'hD000_0000);
        chk("final instrPC", instrPC, 32'h0040_0900);
        chk("final pcAddress", pcAddress, 32'h0040_0904);
        drive(0, 0, 0, 0, 1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
